// File: rtl/ps2_key_tracker.sv
// PS/2 scancode tracker: pops bytes from the keyboard FIFO, follows the held key,
// counts distinct presses in BCD and drives hex/BCD seven-segment digits.
module ps2_key_tracker #(
  parameter int CNT_DIGITS     = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SHOW_EXT       = 1'b1
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic [7:0]                    ps2_data,
  input  logic                          ps2_ready,
  input  logic                          ps2_overflow,
  output logic                          nextdata_n,
  output logic [7:0]                    key_code,
  output logic                          key_ext,
  output logic                          key_pressed,
  output logic [4*CNT_DIGITS-1:0]       press_count,
  output logic                          ovf_seen,
  output logic [8*(2+CNT_DIGITS)-1:0]   o_seg
);

  localparam int         NDIG  = 2 + CNT_DIGITS;
  localparam logic [7:0] BLANK = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {
    S_WAIT,
    S_POP,
    S_GAP
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              byte_q, byte_d;
  logic                    ext_q, ext_d;
  logic                    brk_q, brk_d;
  logic [7:0]              code_q, code_d;
  logic                    kext_q, kext_d;
  logic                    pressed_q, pressed_d;
  logic [4*CNT_DIGITS-1:0] count_q, count_d, count_inc;
  logic                    ovf_q, ovf_d;
  logic [8*NDIG-1:0]       seg_q, seg_d;
  logic                    match;

  function automatic logic [6:0] hexGlyph(input logic [3:0] v);
    case (v)
      4'h0: hexGlyph = 7'h3F;
      4'h1: hexGlyph = 7'h06;
      4'h2: hexGlyph = 7'h5B;
      4'h3: hexGlyph = 7'h4F;
      4'h4: hexGlyph = 7'h66;
      4'h5: hexGlyph = 7'h6D;
      4'h6: hexGlyph = 7'h7D;
      4'h7: hexGlyph = 7'h07;
      4'h8: hexGlyph = 7'h7F;
      4'h9: hexGlyph = 7'h6F;
      4'hA: hexGlyph = 7'h77;
      4'hB: hexGlyph = 7'h7C;
      4'hC: hexGlyph = 7'h39;
      4'hD: hexGlyph = 7'h5E;
      4'hE: hexGlyph = 7'h79;
      default: hexGlyph = 7'h71;
    endcase
  endfunction

  // Same key with the same E0 qualifier as the one currently held.
  assign match = pressed_q && (byte_q == code_q) && (ext_q == kext_q);

  always_comb begin
    logic       carry;
    logic [3:0] digit;
    count_inc = count_q;
    carry     = 1'b1;
    for (int i = 0; i < CNT_DIGITS; i++) begin
      digit = count_q[4*i +: 4];
      if (carry) begin
        if (digit == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = digit + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    code_d    = code_q;
    kext_d    = kext_q;
    pressed_d = pressed_q;
    count_d   = count_q;
    ovf_d     = ovf_q | ps2_overflow;
    case (state_q)
      S_WAIT: begin
        if (ps2_ready) begin
          byte_d  = ps2_data;
          state_d = S_POP;
        end
      end
      S_POP: begin
        state_d = S_GAP;
        if (byte_q == 8'hE0) begin
          ext_d = 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk_d = 1'b1;
        end else begin
          if (brk_q) begin
            if (match) pressed_d = 1'b0;
          end else if (!match) begin
            code_d    = byte_q;
            kext_d    = ext_q;
            pressed_d = 1'b1;
            count_d   = count_inc;
          end
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      end
      S_GAP:   state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
    // An overflow means bytes were lost, so any half-received prefix is untrustworthy.
    if (ps2_overflow) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  always_comb begin
    logic [8*NDIG-1:0] raw;
    raw = '0;
    if (pressed_q) begin
      raw[6:0]  = hexGlyph(code_q[3:0]);
      raw[14:8] = hexGlyph(code_q[7:4]);
      raw[15]   = SHOW_EXT & kext_q;
    end
    for (int i = 0; i < CNT_DIGITS; i++) begin
      raw[8*(i+2) +: 7] = hexGlyph(count_q[4*i +: 4]);
    end
    seg_d = SEG_ACTIVE_LOW ? ~raw : raw;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= S_WAIT;
      byte_q    <= 8'h00;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      code_q    <= 8'h00;
      kext_q    <= 1'b0;
      pressed_q <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      seg_q     <= {NDIG{BLANK}};
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      code_q    <= code_d;
      kext_q    <= kext_d;
      pressed_q <= pressed_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      seg_q     <= seg_d;
    end
  end

  assign nextdata_n  = (state_q != S_POP);
  assign key_code    = code_q;
  assign key_ext     = kext_q;
  assign key_pressed = pressed_q;
  assign press_count = count_q;
  assign ovf_seen    = ovf_q;
  assign o_seg       = seg_q;

endmodule
